// File: rtl/rf_wr_port_arbiter.sv
// Register-file write-port arbiter: the writeback stage has priority, and auxiliary
// results wait in a small in-order queue that drains whenever the port is free.
module rf_wr_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_wr_en,
  input  logic [ADDR_W-1:0] pipe_wr_addr,
  input  logic [DATA_W-1:0] pipe_wr_data,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_data,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [31:0]       pend_mask,
  output logic              stall_req,
  output logic              wr_conflict
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_reg;
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [SC_W-1:0]   starve_cnt_reg, starve_cnt_next;
  logic              stall_reg, stall_next;

  logic pipe_grant, queue_empty, drain, push;
  logic [DEPTH-1:0] conf_hit;

  // A pipe write to r0 is architecturally a no-op, so it leaves the port free.
  assign pipe_grant  = pipe_wr_en && (pipe_wr_addr != '0);
  assign queue_empty = (count_reg == '0);
  assign drain       = !pipe_grant && !queue_empty;
  assign aux_ready   = (count_reg < CNT_W'(DEPTH));
  assign push        = aux_valid && aux_ready && (aux_addr != '0);

  assign rf_wr_en   = rst_n && (pipe_grant || drain);
  assign rf_wr_addr = pipe_grant ? pipe_wr_addr : addr_q[head_reg];
  assign rf_wr_data = pipe_grant ? pipe_wr_data : data_q[head_reg];

  for (genvar gi = 0; gi < 32; gi++) begin : g_pend
    logic [DEPTH-1:0] hit;
    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_slot
      assign hit[gj] = valid_reg[gj] && (addr_q[gj] == ADDR_W'(gi));
    end
    assign pend_mask[gi] = |hit;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_conf
    assign conf_hit[gi] = valid_reg[gi] && (addr_q[gi] == pipe_wr_addr);
  end
  assign wr_conflict = pipe_grant && (|conf_hit);

  assign count_next = count_reg + CNT_W'(push) - CNT_W'(drain);

  // A non-empty queue that is not draining is necessarily blocked by the pipe.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    stall_next      = stall_reg;
    if (queue_empty || drain) begin
      starve_cnt_next = '0;
      stall_next      = 1'b0;
    end else begin
      if (starve_cnt_reg < SC_W'(STARVE_LIMIT))
        starve_cnt_next = starve_cnt_reg + SC_W'(1);
      if (starve_cnt_next == SC_W'(STARVE_LIMIT))
        stall_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg      <= '0;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      starve_cnt_reg <= '0;
      stall_reg      <= 1'b0;
    end else begin
      if (drain) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + PTR_W'(1);
      end
      if (push) begin
        valid_reg[tail_reg] <= 1'b1;
        tail_reg            <= tail_reg + PTR_W'(1);
      end
      count_reg      <= count_next;
      starve_cnt_reg <= starve_cnt_next;
      stall_reg      <= stall_next;
    end
  end

  // Payload storage carries no reset; slot validity is tracked by valid_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_reg] <= aux_addr;
      data_q[tail_reg] <= aux_data;
    end
  end

  assign stall_req = stall_reg;

endmodule

// File: tb/tb_rf_wr_port_arbiter.sv
// Self-checking bench for rf_wr_port_arbiter: a cycle model predicts every output,
// and expected register-file writes flow through a scoreboard queue.
module tb_rf_wr_port_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;
  localparam int LIMIT  = 4;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pipe_wr_en = 1'b0;
  logic [ADDR_W-1:0] pipe_wr_addr = '0;
  logic [DATA_W-1:0] pipe_wr_data = '0;
  logic              aux_valid = 1'b0;
  logic              aux_ready;
  logic [ADDR_W-1:0] aux_addr = '0;
  logic [DATA_W-1:0] aux_data = '0;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [31:0]       pend_mask;
  logic              stall_req;
  logic              wr_conflict;

  rf_wr_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wr_en(pipe_wr_en), .pipe_wr_addr(pipe_wr_addr), .pipe_wr_data(pipe_wr_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .pend_mask(pend_mask), .stall_req(stall_req), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [4:0]  mq_a [$];
  logic [31:0] mq_d [$];
  int          m_starve = 0;
  logic        m_stall = 1'b0;
  wr_t         sb [$];

  logic        obs_en, obs_ready, obs_stall, obs_conf;
  logic [4:0]  obs_addr;
  logic [31:0] obs_data, obs_pend;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, check at posedge+4, advance model at posedge.
  task automatic cycle(input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    logic        grant, drain, e_ready, e_en;
    logic [31:0] e_pend;
    wr_t         w;
    pipe_wr_en = pe; pipe_wr_addr = pa; pipe_wr_data = pd;
    aux_valid = av; aux_addr = aa; aux_data = ad;
    #3;
    grant   = pe && (pa != 5'd0);
    drain   = !grant && (mq_a.size() != 0);
    e_ready = (mq_a.size() < DEPTH);
    e_en    = grant || drain;
    e_pend  = '0;
    foreach (mq_a[i]) e_pend |= 32'd1 << mq_a[i];
    if (grant)      sb.push_back('{a: pa, d: pd});
    else if (drain) sb.push_back('{a: mq_a[0], d: mq_d[0]});

    obs_en = rf_wr_en; obs_addr = rf_wr_addr; obs_data = rf_wr_data;
    obs_ready = aux_ready; obs_pend = pend_mask; obs_stall = stall_req; obs_conf = wr_conflict;

    check_val("rf_wr_en", 32'(obs_en), 32'(e_en));
    check_val("aux_ready", 32'(obs_ready), 32'(e_ready));
    check_val("pend_mask", obs_pend, e_pend);
    check_val("stall_req", 32'(obs_stall), 32'(m_stall));
    check_val("wr_conflict", 32'(obs_conf), 32'(grant && e_pend[pa]));
    if (obs_en) begin
      check_val("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        w = sb.pop_front();
        check_val("wr_addr", 32'(obs_addr), 32'(w.a));
        check_val("wr_data", obs_data, w.d);
        $display("rf write addr=%0d data=%h", obs_addr, obs_data);
      end
    end

    @(posedge clk);
    if (mq_a.size() == 0 || drain) begin
      m_starve = 0;
      m_stall  = 1'b0;
    end else begin
      if (m_starve < LIMIT) m_starve++;
      if (m_starve == LIMIT) m_stall = 1'b1;
    end
    if (drain) begin
      void'(mq_a.pop_front());
      void'(mq_d.pop_front());
    end
    if (av && e_ready && aa != 5'd0) begin
      mq_a.push_back(aa);
      mq_d.push_back(ad);
    end
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd8; pipe_wr_data = 32'h1;
    aux_valid = 1'b1; aux_addr = 5'd3; aux_data = 32'h3;
    #2;
    check_val("rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
    check_val("rst_aux_ready", 32'(aux_ready), 32'd1);
    check_val("rst_pend_mask", pend_mask, 32'd0);
    check_val("rst_stall_req", 32'(stall_req), 32'd0);
    check_val("rst_wr_conflict", 32'(wr_conflict), 32'd0);
    repeat (n) @(posedge clk);
    #1;
    pipe_wr_en = 1'b0; aux_valid = 1'b0;
    rst_n = 1'b1;
    mq_a.delete(); mq_d.delete(); sb.delete();
    m_starve = 0; m_stall = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    apply_reset(2);

    // Pipe grant and r0 write treated as idle
    cycle(1, 5'd8, 32'h1234, 0, 0, 0);
    check_val("t1_en", 32'(obs_en), 32'd1);
    check_val("t1_addr", 32'(obs_addr), 32'd8);
    check_val("t1_data", obs_data, 32'h1234);
    cycle(1, 5'd0, 32'h5555, 0, 0, 0);
    check_val("t1_r0_en", 32'(obs_en), 32'd0);

    // Single aux write with idle pipe
    cycle(0, 0, 0, 1, 5'd9, 32'hBEEF);
    check_val("t2_no_bypass", 32'(obs_en), 32'd0);
    cycle(0, 0, 0, 0, 0, 0);
    check_val("t2_pend", obs_pend, 32'h200);
    check_val("t2_addr", 32'(obs_addr), 32'd9);
    check_val("t2_data", obs_data, 32'hBEEF);
    cycle(0, 0, 0, 0, 0, 0);
    check_val("t2_pend_clr", obs_pend, 32'd0);

    // Fill the queue under continuous pipe writes
    cycle(1, 5'd1, 32'h11, 1, 5'd5, 32'h55);
    cycle(1, 5'd2, 32'h22, 1, 5'd6, 32'h66);
    cycle(1, 5'd3, 32'h33, 1, 5'd7, 32'h77);
    check_val("t3_full_ready", 32'(obs_ready), 32'd0);
    check_val("t3_pend", obs_pend, 32'h60);
    cycle(0, 0, 0, 1, 5'd7, 32'h77);
    check_val("t3_drain5", 32'(obs_addr), 32'd5);
    check_val("t3_ready_full_drain", 32'(obs_ready), 32'd0);
    cycle(0, 0, 0, 1, 5'd7, 32'h77);
    check_val("t3_drain6", 32'(obs_addr), 32'd6);
    check_val("t3_accept7", 32'(obs_ready), 32'd1);
    cycle(0, 0, 0, 0, 0, 0);
    check_val("t3_drain7", 32'(obs_addr), 32'd7);

    // Starvation
    cycle(0, 0, 0, 1, 5'd10, 32'hA0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 5'd1, 32'(i), 0, 0, 0);
      check_val("t4_stall_pre", 32'(obs_stall), 32'd0);
    end
    cycle(0, 0, 0, 0, 0, 0);
    check_val("t4_stall_set", 32'(obs_stall), 32'd1);
    check_val("t4_drain", 32'(obs_addr), 32'd10);
    cycle(0, 0, 0, 0, 0, 0);
    check_val("t4_stall_clr", 32'(obs_stall), 32'd0);

    // Conflict
    cycle(0, 0, 0, 1, 5'd12, 32'h77);
    cycle(1, 5'd12, 32'hAAAA, 0, 0, 0);
    check_val("t5_conflict", 32'(obs_conf), 32'd1);
    check_val("t5_pipe_data", obs_data, 32'hAAAA);
    cycle(0, 0, 0, 0, 0, 0);
    check_val("t5_conflict_clr", 32'(obs_conf), 32'd0);
    check_val("t5_drain_data", obs_data, 32'h77);

    // Reset with two queued entries
    cycle(1, 5'd1, 32'h1, 1, 5'd13, 32'hD);
    cycle(1, 5'd2, 32'h2, 1, 5'd14, 32'hE);
    cycle(1, 5'd3, 32'h3, 0, 0, 0);
    check_val("t6_pend_before", obs_pend, 32'h6000);
    apply_reset(2);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      check_val("t6_no_write", 32'(obs_en), 32'd0);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);
    check_val("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
